exe_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EXE stage of the 5-stage pipeline. It extends the single-cycle ALU with signed/unsigned multiply and divide of configurable width. It drives a stall request so that IF/ID/ID_EXE hold while an operation runs, and it delivers a double-width result on `hi`/`lo`.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/exe_muldiv.sv | 141 ++++++++++++++
 tb/tb_exe_muldiv.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EXE-stage multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_MULU = 2'd1,
    OP_DIV  = 2'd2,
    OP_DIVU = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/exe_muldiv.sv
// Multi-cycle signed/unsigned multiply and divide for the EXE stage.
// Shift-add multiply and restoring divide on magnitudes, sign fix at the end.
module exe_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             r_state;
  state_e             w_next;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_idle;
  logic               w_issue;
  logic               w_sgn;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_aorig;
  logic               w_div0;

  assign w_idle  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_issue = start & ~flush & w_idle;
  assign w_sgn   = (op == OP_MUL) || (op == OP_DIV);
  assign w_sa    = w_sgn & a[WIDTH-1];
  assign w_sb    = w_sgn & b[WIDTH-1];
  assign w_ma    = w_sa ? -a : a;
  assign w_mb    = w_sb ? -b : b;

  // Multiply: low half of r_acc holds the shrinking multiplier.
  assign w_add  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + (r_acc[0] ? {1'b0, r_ma} : '0);
  // Divide: low half of r_acc shifts dividend out, quotient in.
  assign w_sh   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_mb};

  assign w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_q     = r_acc[WIDTH-1:0];
  assign w_r     = r_rem[WIDTH-1:0];
  assign w_div0  = (r_mb == '0);
  assign w_aorig = r_sa ? -r_ma : r_ma;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_DONE: w_next = w_issue ? S_RUN : S_IDLE;
      S_RUN: begin
        if (flush)                     w_next = S_IDLE;
        else if (r_cnt == CW'(1))      w_next = S_FIX;
      end
      S_FIX:  w_next = flush ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_div <= 1'b0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_ma  <= '0;
      r_mb  <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_issue) begin
      r_div <= op[1];
      r_sa  <= w_sa;
      r_sb  <= w_sb;
      r_ma  <= w_ma;
      r_mb  <= w_mb;
      r_acc <= {{WIDTH{1'b0}}, (op[1] ? w_ma : w_mb)};
      r_rem <= '0;
      r_cnt <= CW'(WIDTH);
    end else if (r_state == S_RUN && !flush) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_div) begin
        r_rem <= w_diff[WIDTH] ? w_sh : w_diff;
        r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
        r_acc <= {w_add, r_acc[WIDTH-1:1]};
      end
    end else if (r_state == S_FIX && !flush) begin
      if (!r_div) begin
        {r_hi, r_lo} <= w_prod;
      end else if (w_div0) begin
        r_hi <= w_aorig;
        r_lo <= '1;
      end else begin
        r_hi <= r_sa ? -w_r : w_r;
        r_lo <= (r_sa ^ r_sb) ? -w_q : w_q;
      end
    end
  end

  assign busy  = (r_state == S_RUN) || (r_state == S_FIX);
  assign done  = (r_state == S_DONE);
  assign stall = busy | (start & w_idle);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed and random checks of exe_muldiv against an arithmetic model.
module tb_exe_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op    = 2'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_bad = 0;

  exe_muldiv #(.WIDTH(W)) dut (
    .Clock (clk),
    .Resetn(rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    p  = '0;
    case (o)
      2'd0: p = sx * sy;
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else        p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 chk("stall_issue", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int e0, output int edges, output int stl);
    edges = e0;
    stl   = 0;
    while (done !== 1'b1 && edges < 60) begin
      if (stall === 1'b1) stl++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] exp;
    int e, s;
    exp = model(o, x, y);
    issue(o, x, y);
    wait_done(1, e, s);
    chk({tag, " latency"}, 64'(e), 64'(W + 2));
    chk({tag, " stall_cycles"}, 64'(s), 64'(W + 1));
    chk({tag, " hilo"}, {hi, lo}, exp);
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] save, exp;
    logic [1:0]  ro;
    logic [W-1:0] ra, rb;
    int e, s;
    bit seen;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst hilo", {hi, lo}, 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mulu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulu_max k", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mul_neg", 2'd0, -32'sd3, 32'd5);
    chk("mul_neg k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_neg", 2'd2, -32'sd7, 32'd2);
    chk("div_neg k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf k", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_zero", 2'd3, 32'h1234, 32'd0);
    chk("divu_zero k", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op("div_zero", 2'd2, 32'h1234, 32'd0);
    chk("div_zero k", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op("div_zero_neg", 2'd2, 32'hFFFF_0000, 32'd0);

    save = {hi, lo};
    issue(2'd0, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush hilo", {hi, lo}, save);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("flush no_done", 64'(seen), 64'd0);
    chk("flush hold", {hi, lo}, save);

    exp = model(2'd1, 32'hDEAD_BEEF, 32'h0000_1001);
    issue(2'd1, 32'hDEAD_BEEF, 32'h0000_1001);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, e, s);
    chk("ign latency", 64'(e), 64'(W + 2));
    chk("ign hilo", {hi, lo}, exp);

    exp = model(2'd2, 32'hFFFF_FF9C, 32'd7);
    start = 1'b1; op = 2'd2; a = 32'hFFFF_FF9C; b = 32'd7;
    #1 chk("b2b stall", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", 64'(busy), 64'd1);
    wait_done(1, e, s);
    chk("b2b latency", 64'(e), 64'(W + 2));
    chk("b2b hilo", {hi, lo}, exp);
    @(negedge clk);

    issue(2'd0, 32'd77, 32'd99);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst hilo", {hi, lo}, 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'd3, 32'd1000, 32'd33);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = -W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op("rnd", ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
